// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB responder: FSM encoding, bit-count markers
// and the default device ID.
package sccb_pkg;

  localparam int         SCCB_BITS_PER_PHASE = 9;
  localparam logic [7:0] SCCB_DEV_ID_DEFAULT = 8'h42;
  localparam int         REG_DEPTH           = 256;

  // Bit-counter markers derived from the 9-bit phase length
  localparam logic [3:0] CNT_LAST_DATA = 4'(SCCB_BITS_PER_PHASE - 2);
  localparam logic [3:0] CNT_BYTE_DONE = 4'(SCCB_BITS_PER_PHASE - 1);
  localparam logic [3:0] CNT_ACK_BIT   = 4'(SCCB_BITS_PER_PHASE);
  localparam logic [3:0] CNT_ACK_OK    = 4'(SCCB_BITS_PER_PHASE + 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_SUB,
    ST_ACK_SUB,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_RD_ACKBIT,
    ST_IGNORE
  } sccb_state_e;

  function automatic logic mid_byte(input logic [3:0] done_bits);
    return (done_bits != 4'd0) && (done_bits <= CNT_LAST_DATA);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizes the SCCB lines into sys_clk and flags SCL edges and
// START/STOP line conditions.
module sccb_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_d_reg;
  logic                   sda_d_reg;
  logic                   scl_s;

  // Idle bus is high; resetting to 1 avoids phantom edges when reset releases
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_d_reg    <= 1'b1;
      sda_d_reg    <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl_i};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_i};
      scl_d_reg    <= scl_s;
      sda_d_reg    <= sda_s;
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d_reg;
  assign scl_fall  = ~scl_s & scl_d_reg;
  assign start_det = scl_s & scl_d_reg & sda_d_reg & ~sda_s;
  assign stop_det  = scl_s & scl_d_reg & ~sda_d_reg & sda_s;

endmodule

// File: rtl/sccb_slave_responder.sv
// SCCB configuration-port responder: decodes 3-phase writes and 2-phase
// write + 2-phase read transactions against a 256x8 register file.
module sccb_slave_responder
  import sccb_pkg::*;
#(
  parameter logic [7:0] DEV_ID      = SCCB_DEV_ID_DEFAULT,
  parameter bit         ACK_EN      = 1'b1,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] REG_INIT    = 8'h00
) (
  input  logic       sys_clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic       busy,
  output logic       proto_err
);

  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  sccb_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .sys_clk  (sys_clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  sccb_state_e state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic        bit_open_reg, bit_open_next;
  logic [7:0]  rx_shift_reg, rx_shift_next;
  logic [7:0]  tx_shift_reg, tx_shift_next;
  logic [7:0]  ptr_reg, ptr_next;
  logic        rd_mode_reg, rd_mode_next;
  logic        sda_oe_reg, sda_oe_next;
  logic        wr_valid_reg, wr_valid_next;
  logic [7:0]  wr_addr_reg, wr_addr_next;
  logic [7:0]  wr_data_reg, wr_data_next;
  logic        rd_valid_reg, rd_valid_next;
  logic [7:0]  rd_addr_reg, rd_addr_next;
  logic        proto_err_reg, proto_err_next;

  logic [7:0]  reg_file [REG_DEPTH];
  logic [7:0]  rd_data_reg;
  logic        mem_we;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_wdata;

  logic [7:0]  rx_byte;
  logic [3:0]  done_bits;

  assign rx_byte = {rx_shift_reg[6:0], sda_s};
  // The SCL rise that precedes START/STOP opens a bit that never completes
  assign done_bits = bit_cnt_reg - {3'b000, bit_open_reg};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 4'd0;
      bit_open_reg  <= 1'b0;
      rx_shift_reg  <= 8'h00;
      tx_shift_reg  <= 8'h00;
      ptr_reg       <= 8'h00;
      rd_mode_reg   <= 1'b0;
      sda_oe_reg    <= 1'b0;
      wr_valid_reg  <= 1'b0;
      wr_addr_reg   <= 8'h00;
      wr_data_reg   <= 8'h00;
      rd_valid_reg  <= 1'b0;
      rd_addr_reg   <= 8'h00;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bit_cnt_reg   <= bit_cnt_next;
      bit_open_reg  <= bit_open_next;
      rx_shift_reg  <= rx_shift_next;
      tx_shift_reg  <= tx_shift_next;
      ptr_reg       <= ptr_next;
      rd_mode_reg   <= rd_mode_next;
      sda_oe_reg    <= sda_oe_next;
      wr_valid_reg  <= wr_valid_next;
      wr_addr_reg   <= wr_addr_next;
      wr_data_reg   <= wr_data_next;
      rd_valid_reg  <= rd_valid_next;
      rd_addr_reg   <= rd_addr_next;
      proto_err_reg <= proto_err_next;
    end
  end

  // Register file with a registered read port addressed by the pointer
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        reg_file[i] <= REG_INIT;
      end
      rd_data_reg <= REG_INIT;
    end else begin
      if (mem_we) begin
        reg_file[mem_waddr] <= mem_wdata;
      end
      rd_data_reg <= reg_file[ptr_reg];
    end
  end

  always_comb begin
    state_next     = state_reg;
    bit_cnt_next   = bit_cnt_reg;
    bit_open_next  = bit_open_reg;
    rx_shift_next  = rx_shift_reg;
    tx_shift_next  = tx_shift_reg;
    ptr_next       = ptr_reg;
    rd_mode_next   = rd_mode_reg;
    sda_oe_next    = sda_oe_reg;
    wr_valid_next  = 1'b0;
    wr_addr_next   = wr_addr_reg;
    wr_data_next   = wr_data_reg;
    rd_valid_next  = 1'b0;
    rd_addr_next   = rd_addr_reg;
    proto_err_next = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = ptr_reg;
    mem_wdata      = rx_byte;

    if (scl_rise) begin
      bit_open_next = 1'b1;
    end else if (scl_fall) begin
      bit_open_next = 1'b0;
    end

    if (stop_det) begin
      state_next     = ST_IDLE;
      bit_cnt_next   = 4'd0;
      bit_open_next  = 1'b0;
      sda_oe_next    = 1'b0;
      proto_err_next = mid_byte(done_bits);
    end else if (start_det) begin
      state_next     = ST_DEV;
      bit_cnt_next   = 4'd0;
      bit_open_next  = 1'b0;
      proto_err_next = mid_byte(done_bits);
    end else begin
      case (state_reg)
        ST_DEV, ST_SUB, ST_WDATA: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
          end
          if (scl_rise) begin
            rx_shift_next = rx_byte;
            bit_cnt_next  = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == CNT_LAST_DATA) begin
              if (state_reg == ST_DEV) begin
                if (rx_byte == DEV_ID) begin
                  state_next   = ST_ACK_DEV;
                  rd_mode_next = 1'b0;
                end else if (rx_byte == RD_ID) begin
                  state_next   = ST_ACK_DEV;
                  rd_mode_next = 1'b1;
                end else begin
                  state_next = ST_IGNORE;
                end
              end else if (state_reg == ST_SUB) begin
                ptr_next   = rx_byte;
                state_next = ST_ACK_SUB;
              end else begin
                mem_we        = 1'b1;
                wr_valid_next = 1'b1;
                wr_addr_next  = ptr_reg;
                wr_data_next  = rx_byte;
                ptr_next      = ptr_reg + 8'd1;
                state_next    = ST_ACK_WDATA;
              end
            end
          end
        end

        // First fall opens the 9th bit, second fall closes it
        ST_ACK_DEV, ST_ACK_SUB, ST_ACK_WDATA: begin
          if (scl_fall) begin
            if (bit_cnt_reg == CNT_BYTE_DONE) begin
              sda_oe_next  = ACK_EN;
              bit_cnt_next = CNT_ACK_BIT;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = 4'd0;
              if (state_reg == ST_ACK_DEV && rd_mode_reg) begin
                state_next    = ST_RDATA;
                tx_shift_next = rd_data_reg;
                sda_oe_next   = ~rd_data_reg[7];
              end else if (state_reg == ST_ACK_DEV) begin
                state_next = ST_SUB;
              end else begin
                state_next = ST_WDATA;
              end
            end
          end
        end

        ST_RDATA: begin
          if (scl_rise) begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == CNT_LAST_DATA) begin
              rd_valid_next = 1'b1;
              rd_addr_next  = ptr_reg;
              ptr_next      = ptr_reg + 8'd1;
              state_next    = ST_RD_ACKBIT;
            end
          end else if (scl_fall && bit_cnt_reg != 4'd0) begin
            tx_shift_next = {tx_shift_reg[6:0], 1'b0};
            sda_oe_next   = ~tx_shift_reg[6];
          end
        end

        ST_RD_ACKBIT: begin
          if (scl_fall) begin
            if (bit_cnt_reg == CNT_BYTE_DONE) begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = CNT_ACK_BIT;
            end else if (bit_cnt_reg == CNT_ACK_OK) begin
              state_next    = ST_RDATA;
              bit_cnt_next  = 4'd0;
              tx_shift_next = rd_data_reg;
              sda_oe_next   = ~rd_data_reg[7];
            end
          end else if (scl_rise && bit_cnt_reg == CNT_ACK_BIT) begin
            if (sda_s) begin
              state_next = ST_IGNORE;
            end else begin
              bit_cnt_next = CNT_ACK_OK;
            end
          end
        end

        ST_IGNORE: begin
          if (scl_fall) begin
            sda_oe_next = 1'b0;
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign sda_oe    = sda_oe_reg;
  assign wr_valid  = wr_valid_reg;
  assign wr_addr   = wr_addr_reg;
  assign wr_data   = wr_data_reg;
  assign rd_valid  = rd_valid_reg;
  assign rd_addr   = rd_addr_reg;
  assign proto_err = proto_err_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_sccb_slave_responder.sv
// Directed bench: a bit-banged SCCB master drives the responder through
// table-driven write/read-back vectors and hand-written corner sequences.
module tb_sccb_slave_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, wr_valid, rd_valid, busy, proto_err;
  logic [7:0] wr_addr, wr_data, rd_addr;
  wire        sda_line = sda_m & ~sda_oe;

  always #25 clk = ~clk;  // 20 MHz

  sccb_slave_responder dut (
    .sys_clk  (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_m),
    .sda_i    (sda_line),
    .sda_oe   (sda_oe),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_valid (rd_valid),
    .rd_addr  (rd_addr),
    .busy     (busy),
    .proto_err(proto_err)
  );

  int n_pass = 0;
  int n_total = 0;
  int q_cycles = 50;  // quarter SCL period in sys_clk cycles

  // Pulse monitor
  int         wr_cnt = 0, rd_cnt = 0, perr_cnt = 0, oe_cnt = 0;
  logic [7:0] wr_addr_log [64];
  logic [7:0] wr_data_log [64];

  always @(negedge clk) begin
    if (wr_valid) begin
      wr_addr_log[wr_cnt % 64] = wr_addr;
      wr_data_log[wr_cnt % 64] = wr_data;
      wr_cnt++;
    end
    if (rd_valid) rd_cnt++;
    if (proto_err) perr_cnt++;
    if (sda_oe) oe_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic qwait;
    repeat (q_cycles) @(negedge clk);
  endtask

  task automatic sccb_start;
    sda_m = 1'b1; scl_m = 1'b1; qwait;
    sda_m = 1'b0; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic sccb_stop;
    sda_m = 1'b0; qwait;
    scl_m = 1'b1; qwait;
    sda_m = 1'b1; qwait; qwait;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait;
    scl_m = 1'b1; qwait; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic recv_bit(output logic b);
    sda_m = 1'b1; qwait;
    scl_m = 1'b1; qwait;
    b = sda_line; qwait;
    scl_m = 1'b0; qwait;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic na);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(na);
  endtask

  task automatic write_txn(input logic [7:0] addr, input logic [7:0] data, output logic [2:0] acks);
    sccb_start;
    send_byte(8'h42, acks[2]);
    send_byte(addr, acks[1]);
    send_byte(data, acks[0]);
    sccb_stop;
  endtask

  task automatic read_txn(input logic [7:0] addr, input bit set_ptr, output logic [7:0] d);
    logic a;
    if (set_ptr) begin
      sccb_start;
      send_byte(8'h42, a);
      send_byte(addr, a);
      sccb_stop;
    end
    sccb_start;
    send_byte(8'h43, a);
    recv_byte(d, 1'b1);
    sccb_stop;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] nxt_addr;
    logic [7:0] nxt_data;
  } vec_t;

  vec_t vecs [4];

  initial begin
    logic [2:0] acks;
    logic [3:0] acks4;
    logic [7:0] d, d2;
    int         wr0, rd0, perr0, oe0;

    vecs[0] = '{addr: 8'h12, data: 8'h80, nxt_addr: 8'h13, nxt_data: 8'h00};
    vecs[1] = '{addr: 8'h0A, data: 8'h76, nxt_addr: 8'h0B, nxt_data: 8'h00};
    vecs[2] = '{addr: 8'h00, data: 8'h5A, nxt_addr: 8'h01, nxt_data: 8'h00};
    vecs[3] = '{addr: 8'hFF, data: 8'hC3, nxt_addr: 8'h00, nxt_data: 8'h5A};

    repeat (5) @(negedge clk);
    check("reset_outputs", {sda_oe, wr_valid, rd_valid, busy, proto_err, wr_addr, wr_data, rd_addr}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Write, 2-phase pointer set + read back, then a read from the incremented pointer
    for (int v = 0; v < 4; v++) begin
      q_cycles = (v == 0) ? 50 : 25;
      wr0 = wr_cnt; rd0 = rd_cnt;
      write_txn(vecs[v].addr, vecs[v].data, acks);
      check("acks", acks, 3'b000);
      check("wr_count", wr_cnt - wr0, 1);
      check("wr_addr", wr_addr, vecs[v].addr);
      check("wr_data", wr_data, vecs[v].data);
      read_txn(vecs[v].addr, 1'b1, d);
      check("rd_data", d, vecs[v].data);
      check("rd_addr", rd_addr, vecs[v].addr);
      check("rd_count", rd_cnt - rd0, 1);
      read_txn(8'h00, 1'b0, d2);
      check("next_rd_data", d2, vecs[v].nxt_data);
      check("next_rd_addr", rd_addr, vecs[v].nxt_addr);
      check("busy_idle", busy, 1'b0);
      $display("vec %0d: wrote %02h to %02h, read %02h, next %02h=%02h", v, vecs[v].data, vecs[v].addr, d, rd_addr, d2);
    end
    q_cycles = 25;

    // Foreign device ID: never acknowledged, nothing written
    wr0 = wr_cnt; oe0 = oe_cnt;
    sccb_start;
    send_byte(8'h60, acks4[3]);
    send_byte(8'hAA, acks4[2]);
    send_byte(8'h55, acks4[1]);
    send_byte(8'h11, acks4[0]);
    check("ignore_busy", busy, 1'b1);
    sccb_stop;
    check("ignore_acks", acks4, 4'b1111);
    check("ignore_oe", oe_cnt - oe0, 0);
    check("ignore_wr", wr_cnt - wr0, 0);
    check("ignore_idle", busy, 1'b0);
    $display("foreign id 60: acks=%b", acks4);

    // STOP after 4 data bits
    wr0 = wr_cnt; perr0 = perr_cnt;
    sccb_start;
    send_byte(8'h42, acks[2]);
    send_byte(8'h20, acks[1]);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    sccb_stop;
    check("perr_count", perr_cnt - perr0, 1);
    check("perr_idle", busy, 1'b0);
    check("perr_no_wr", wr_cnt - wr0, 0);
    read_txn(8'h20, 1'b1, d);
    check("perr_reg", d, 8'h00);
    check("perr_clean_stops", perr_cnt - perr0, 1);
    $display("partial stop at 42/20: reg20=%02h", d);

    // Multi-byte write across the pointer wrap
    wr0 = wr_cnt;
    sccb_start;
    send_byte(8'h42, acks[2]);
    send_byte(8'hFF, acks[1]);
    send_byte(8'h11, acks[0]);
    send_byte(8'h22, acks4[0]);
    sccb_stop;
    check("multi_acks", {acks, acks4[0]}, 4'b0000);
    check("multi_wr_count", wr_cnt - wr0, 2);
    check("multi_wr0", {wr_addr_log[wr0 % 64], wr_data_log[wr0 % 64]}, 16'hFF11);
    check("multi_wr1", {wr_addr_log[(wr0 + 1) % 64], wr_data_log[(wr0 + 1) % 64]}, 16'h0022);
    sccb_start;
    send_byte(8'h42, acks[2]);
    send_byte(8'hFF, acks[1]);
    sccb_stop;
    sccb_start;
    send_byte(8'h43, acks[0]);
    recv_byte(d, 1'b0);
    recv_byte(d2, 1'b1);
    sccb_stop;
    check("multi_rd", {d, d2}, 16'h1122);
    check("multi_rd_addr", rd_addr, 8'h00);
    $display("multi-byte FF: read %02h %02h", d, d2);

    // Reset asserted while the sub-address ACK is being driven
    sccb_start;
    send_byte(8'h42, acks[2]);
    for (int i = 7; i >= 0; i--) send_bit(i == 2 || i == 0);
    check("ack_sub_oe", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_release_oe", sda_oe, 1'b0);
    check("reset_busy", busy, 1'b0);
    scl_m = 1'b1;
    repeat (3) @(negedge clk);
    sda_m = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    wr0 = wr_cnt;
    write_txn(8'h05, 8'h33, acks);
    check("post_reset_acks", acks, 3'b000);
    check("post_reset_wr", {wr_addr, wr_data}, 16'h0533);
    check("post_reset_wr_count", wr_cnt - wr0, 1);
    read_txn(8'h05, 1'b1, d);
    check("post_reset_rd", d, 8'h33);
    $display("post-reset 42/05/33: read %02h", d);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sccb_slave_responder.md
Name: sccb_slave_responder

Overview:
- Synthesizable SCCB responder that models the camera's configuration port.
- Pairs with the SCCB master inside OV7670_SDRAM_VGA on SCCB_SCL/SCCB_SDA in system simulation; also usable as a loopback target on hardware.
- Oversamples SCL/SDA in the sys_clk domain and decodes 3-phase writes and 2-phase write + 2-phase read transactions.
- Holds a 256x8 register file and reports every committed write and every served read for scoreboarding.

Parameters:
- DEV_ID, 8'h42, write device ID; read ID is DEV_ID|8'h01.
- ACK_EN, 1, 1 = drive SDA low in the 9th bit after an accepted ID/sub-address/write byte; 0 = release SDA in every 9th bit (SCCB don't-care).
- SYNC_STAGES, 2, synchronizer depth for scl_i/sda_i (minimum 2).
- REG_INIT, 8'h00, reset value of every register-file entry.

Ports:
- sys_clk  in  1  system clock; must be at least 8x the SCL frequency.
- rst_n  in  1  asynchronous active-low reset.
- scl_i  in  1  SCCB clock from the master (open-drain, already resolved).
- sda_i  in  1  resolved SDA line level.
- sda_oe  out  1  1 = pull SDA low; 0 = release. Never drives high.
- wr_valid  out  1  one-cycle pulse when a write data byte is committed.
- wr_addr  out  8  register address of the committed write.
- wr_data  out  8  data of the committed write.
- rd_valid  out  1  one-cycle pulse when a read byte has been fully shifted out.
- rd_addr  out  8  address that was read.
- busy  out  1  high from START until STOP, or until the IDLE return after an error.
- proto_err  out  1  one-cycle pulse on STOP or START arriving mid-byte (bit count 1..7).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; sub-address pointer 0; all registers = REG_INIT.
  - Reset mid-transaction releases SDA on the same assertion; no partial write is committed.
- Input conditioning:
  - scl_i and sda_i pass through SYNC_STAGES flops, then a one-flop edge detector.
  - Decode latency from pin to decision is SYNC_STAGES+1 cycles.
- Line conditions (evaluated on synced signals):
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Data bits are sampled MSB first on the SCL rising edge.
  - sda_oe changes only on the SCL falling edge. Exception: reset and STOP release it immediately.
- States: IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WDATA, RDATA, RD_ACKBIT, IGNORE.
- Transitions:
  - IDLE -> DEV on START.
  - DEV: after 8 bits:
    - byte == DEV_ID -> ACK_DEV, write mode.
    - byte == DEV_ID|1 -> ACK_DEV, read mode; the first data bit is loaded on the falling edge that ends ACK_DEV.
    - otherwise -> IGNORE; SDA is never driven.
  - ACK_DEV -> SUB (write mode) or RDATA (read mode) after the 9th SCL falling edge.
  - SUB: after 8 bits, load the pointer -> ACK_SUB -> WDATA.
  - WDATA: after 8 bits:
    - reg[pointer] <= byte.
    - wr_valid pulses 1 cycle after the 8th rising edge, with wr_addr = pointer and wr_data = byte.
    - pointer increments mod 256.
    - -> ACK_WDATA -> WDATA, so additional bytes continue writing.
  - RDATA: shifts reg[pointer] out MSB first. After 8 bits:
    - rd_valid pulses and rd_addr = pointer.
    - pointer increments mod 256.
    - -> RD_ACKBIT; SDA is released.
  - RD_ACKBIT: sample the master's bit. 0 -> RDATA for the next byte; 1 (NA) -> IGNORE until STOP.
  - ACK states: sda_oe = ACK_EN during the 9th bit, released on the following falling edge.
- START in any state (repeated start): bit counter clears and state -> DEV; the pointer is retained. If bit count is 1..7, proto_err also pulses.
- STOP in any state:
  - state -> IDLE, busy = 0.
  - A partially received byte is discarded and proto_err pulses if bit count is 1..7.
  - A STOP right after SUB/ACK_SUB leaves the pointer set; this is the 2-phase write that precedes a read.
- Pointer wrap: 0xFF + 1 = 0x00.
- A write and a read never coincide, so there is no simultaneous-access hazard.

Decomposition:
- Package sccb_pkg: state enum encoding, SCCB_BITS_PER_PHASE = 9, default DEV_ID 8'h42.
- One sub-module, sccb_line_sync: synchronizers, edge detect, and START/STOP detection. Outputs scl_rise, scl_fall, sda_s, start_det, stop_det.
- The FSM, shift register, pointer and register file live in the top module.

Test Plan:
- 3-phase write 42/12/80 at 100 kHz SCL, sys_clk 20 MHz -> wr_valid pulses once with wr_addr=0x12, wr_data=0x80; sda_oe asserted in all three 9th bits; reg[0x12]=0x80.
- Write 42/0A/76, STOP, 2-phase write 42/0A, STOP, read 43 with NA -> master samples 0x76; rd_valid with rd_addr=0x0A; pointer is 0x0B afterwards.
- ID 0x60 followed by 3 bytes -> sda_oe stays 0 throughout; no wr_valid; busy is 1 until STOP.
- STOP after 4 bits of the data byte in a 42/20 write -> proto_err pulses; reg[0x20] is unchanged; state is IDLE.
- Write 42/FF then 11, 22 (multi-byte) -> reg[0xFF]=0x11, reg[0x00]=0x22; two wr_valid pulses.
- rst_n low during ACK_SUB while sda_oe=1 -> sda_oe=0 immediately; after release, the next transaction 42/05/33 commits normally.
